// File: rtl/sd_pack_up.sv
// Packs `lanes` narrow beats from an srdy/drdy producer into one wide word.
// A c_last beat closes the word early; p_mask marks which lanes were filled.
module sd_pack_up #(
  parameter int width = 8,
  parameter int lanes = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     c_srdy,
  output logic                     c_drdy,
  input  logic [width-1:0]         c_data,
  input  logic                     c_last,
  output logic                     p_srdy,
  input  logic                     p_drdy,
  output logic [width*lanes-1:0]   p_data,
  output logic [lanes-1:0]         p_mask,
  output logic                     p_last
);

  localparam int cnt_w = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [cnt_w-1:0] last_lane = cnt_w'(lanes - 1);

  logic [cnt_w-1:0]       cnt;
  logic [width-1:0]       acc [lanes-1];
  logic                   beat_xfer;
  logic                   word_xfer;
  logic                   word_done;
  logic [width*lanes-1:0] word_next;
  logic [lanes-1:0]       mask_next;

  // The output register frees up on the same edge it is drained, so a new
  // word can be loaded back-to-back without a bubble.
  assign c_drdy    = !p_srdy || p_drdy;
  assign beat_xfer = c_srdy && c_drdy;
  assign word_xfer = p_srdy && p_drdy;
  assign word_done = beat_xfer && (c_last || (cnt == last_lane));

  always_comb begin
    word_next = '0;
    mask_next = '0;
    for (int i = 0; i < lanes - 1; i++) begin
      if (cnt_w'(i) < cnt) word_next[i*width +: width] = acc[i];
    end
    for (int i = 0; i < lanes; i++) begin
      if (cnt_w'(i) == cnt) word_next[i*width +: width] = c_data;
      mask_next[i] = (cnt_w'(i) <= cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int i = 0; i < lanes - 1; i++) acc[i] <= '0;
    end else if (beat_xfer) begin
      if (word_done) begin
        cnt <= '0;
      end else begin
        for (int i = 0; i < lanes - 1; i++) begin
          if (cnt == cnt_w'(i)) acc[i] <= c_data;
        end
        cnt <= cnt + cnt_w'(1);
      end
    end
  end

  // Stale accumulator lanes never leak out: word_next zeroes unfilled lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_srdy <= 1'b0;
      p_data <= '0;
      p_mask <= '0;
      p_last <= 1'b0;
    end else if (word_done) begin
      p_srdy <= 1'b1;
      p_data <= word_next;
      p_mask <= mask_next;
      p_last <= c_last;
    end else if (word_xfer) begin
      p_srdy <= 1'b0;
    end
  end

  a_mask_nonzero: assert property (@(posedge clk) disable iff (!reset)
    p_srdy |-> (p_mask != '0));

  a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
    cnt <= last_lane);

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!reset)
    (p_srdy && !p_drdy) |=> (p_srdy && $stable(p_data) && $stable(p_mask) && $stable(p_last)));

endmodule

// File: tb/tb_sd_pack_up.sv
// Bench for sd_pack_up: queue-based word model checked every cycle, plus
// directed literal cases and a throttled random stream unpacked by p_mask.
module tb_sd_pack_up;
  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           c_srdy;
  logic           c_drdy;
  logic [W-1:0]   c_data;
  logic           c_last;
  logic           p_srdy;
  logic           p_drdy;
  logic [W*L-1:0] p_data;
  logic [L-1:0]   p_mask;
  logic           p_last;

  int checks = 0;
  int failures = 0;
  int drdy_mode = 0;
  logic [7:0] drdy_pat = 8'hA5;
  logic monitor_on = 1'b0;
  int drdy_low = 0;

  logic [W*L-1:0] exp_data_q [$];
  logic [L-1:0]   exp_mask_q [$];
  logic           exp_last_q [$];
  logic [W-1:0]   part_q [$];
  logic [W*L-1:0] got_data_q [$];
  logic [L-1:0]   got_mask_q [$];
  logic           got_last_q [$];

  sd_pack_up #(.width(W), .lanes(L)) dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_last(c_last),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_mask(p_mask), .p_last(p_last)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: collect accepted beats; a word exists once lanes beats or a
  // c_last beat have arrived, and leaves when the consumer takes it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_data_q.delete();
      exp_mask_q.delete();
      exp_last_q.delete();
      part_q.delete();
    end else begin
      if (p_srdy && p_drdy) begin
        got_data_q.push_back(p_data);
        got_mask_q.push_back(p_mask);
        got_last_q.push_back(p_last);
        if (exp_data_q.size() > 0) begin
          void'(exp_data_q.pop_front());
          void'(exp_mask_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      if (c_srdy && c_drdy) begin
        part_q.push_back(c_data);
        if (part_q.size() == L || c_last) begin
          logic [W*L-1:0] d;
          logic [L-1:0] m;
          d = '0;
          m = '0;
          for (int i = 0; i < part_q.size(); i++) begin
            d[i*W +: W] = part_q[i];
            m[i] = 1'b1;
          end
          exp_data_q.push_back(d);
          exp_mask_q.push_back(m);
          exp_last_q.push_back(c_last);
          part_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check_output("p_srdy", p_srdy, exp_data_q.size() > 0);
      check_output("c_drdy", c_drdy, (exp_data_q.size() == 0) || p_drdy);
      if (exp_data_q.size() > 0) begin
        check_output("p_data", p_data, exp_data_q[0]);
        check_output("p_mask", p_mask, exp_mask_q[0]);
        check_output("p_last", p_last, exp_last_q[0]);
      end
      if (monitor_on && !c_drdy) drdy_low++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (drdy_mode)
      0: p_drdy = 1'b1;
      1: begin
        p_drdy = drdy_pat[0];
        drdy_pat = {drdy_pat[0], drdy_pat[7:1]};
      end
      2: p_drdy = 1'b0;
      default: p_drdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Called at posedge+1; returns at posedge+1 just after the beat transferred.
  task automatic apply_stimulus(input logic [W-1:0] d, input logic last);
    int guard;
    logic ok;
    guard = 0;
    c_srdy = 1'b1;
    c_data = d;
    c_last = last;
    forever begin
      @(negedge clk);
      ok = c_drdy;
      @(posedge clk);
      if (ok) break;
      guard++;
      if (guard > 200) begin
        check_output("c_drdy_timeout", 0, 1);
        break;
      end
    end
    #1;
    c_srdy = 1'b0;
    c_last = 1'b0;
  endtask

  task automatic idle(input int n);
    c_srdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    drdy_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_data_q.delete();
    got_mask_q.delete();
    got_last_q.delete();
  endtask

  task automatic expect_word(input int k, input logic [W*L-1:0] d, input logic [L-1:0] m, input logic last);
    if (k >= got_data_q.size()) begin
      check_output("word_missing", k, got_data_q.size());
    end else begin
      check_output("log_data", got_data_q[k], d);
      check_output("log_mask", got_mask_q[k], m);
      check_output("log_last", got_last_q[k], last);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] srdy_pat;
    logic [7:0] seq;
    logic [7:0] exp_b;
    int total;
    int guard;

    reset = 1'b0;
    c_srdy = 1'b0;
    c_data = '0;
    c_last = 1'b0;
    p_drdy = 1'b1;

    repeat (3) @(negedge clk);
    check_output("rst_p_srdy", p_srdy, 0);
    check_output("rst_p_data", p_data, 0);
    check_output("rst_p_mask", p_mask, 0);
    check_output("rst_p_last", p_last, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check_output("c_drdy_after_reset", c_drdy, 1);
    @(posedge clk);
    #1;

    $display("[TB] streaming");
    clear_log();
    monitor_on = 1'b1;
    for (int i = 0; i < 12; i++) apply_stimulus(W'(i), 1'b0);
    monitor_on = 1'b0;
    idle(3);
    check_output("stream_count", got_data_q.size(), 3);
    expect_word(0, 32'h03020100, 4'hF, 1'b0);
    expect_word(1, 32'h07060504, 4'hF, 1'b0);
    expect_word(2, 32'h0B0A0908, 4'hF, 1'b0);
    check_output("stream_c_drdy_low", drdy_low, 0);

    $display("[TB] early close");
    clear_log();
    apply_stimulus(8'h11, 1'b0);
    apply_stimulus(8'h22, 1'b0);
    apply_stimulus(8'h33, 1'b1);
    apply_stimulus(8'h44, 1'b1);
    idle(3);
    check_output("early_count", got_data_q.size(), 2);
    expect_word(0, 32'h00332211, 4'h7, 1'b1);
    expect_word(1, 32'h00000044, 4'h1, 1'b1);

    $display("[TB] backpressure");
    clear_log();
    set_mode(2);
    for (int i = 0; i < 4; i++) apply_stimulus(W'(i), 1'b0);
    fork
      begin
        for (int i = 4; i < 8; i++) apply_stimulus(W'(i), 1'b0);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          check_output("stall_c_drdy", c_drdy, 0);
          check_output("stall_p_srdy", p_srdy, 1);
          check_output("stall_p_data", p_data, 32'h03020100);
        end
        drdy_mode = 0;
      end
    join
    idle(3);
    check_output("bp_count", got_data_q.size(), 2);
    expect_word(0, 32'h03020100, 4'hF, 1'b0);
    expect_word(1, 32'h07060504, 4'hF, 1'b0);

    $display("[TB] simultaneous drain and load");
    clear_log();
    apply_stimulus(8'h55, 1'b1);
    apply_stimulus(8'h66, 1'b1);
    @(negedge clk);
    check_output("simul_p_srdy", p_srdy, 1);
    check_output("simul_p_data", p_data, 32'h00000066);
    check_output("simul_p_mask", p_mask, 4'h1);
    @(posedge clk);
    #1;
    idle(2);
    check_output("simul_count", got_data_q.size(), 2);
    expect_word(0, 32'h00000055, 4'h1, 1'b1);
    expect_word(1, 32'h00000066, 4'h1, 1'b1);

    $display("[TB] reset mid-word");
    clear_log();
    apply_stimulus(8'h77, 1'b0);
    apply_stimulus(8'h78, 1'b0);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(8'hA0 + 8'(i), 1'b0);
    idle(3);
    check_output("rst_word_count", got_data_q.size(), 1);
    expect_word(0, 32'hA3A2A1A0, 4'hF, 1'b0);

    $display("[TB] reset mid-stall");
    clear_log();
    set_mode(2);
    for (int i = 0; i < 4; i++) apply_stimulus(8'hC0 + 8'(i), 1'b0);
    #2 reset = 1'b0;
    #1;
    check_output("async_p_srdy", p_srdy, 0);
    check_output("async_p_data", p_data, 0);
    check_output("async_p_mask", p_mask, 0);
    drdy_mode = 0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    idle(5);
    check_output("stall_rst_count", got_data_q.size(), 0);

    $display("[TB] random stream");
    clear_log();
    @(negedge clk);
    drdy_pat = 8'hA5;
    drdy_mode = 1;
    @(posedge clk);
    #1;
    srdy_pat = 8'h5A;
    seq = 8'h00;
    for (int n = 0; n < 1000; n++) begin
      if (srdy_pat[0]) idle(1);
      srdy_pat = {srdy_pat[0], srdy_pat[7:1]};
      apply_stimulus(seq, (n == 999) || ($urandom_range(0, 7) == 0));
      seq = seq + 8'd1;
    end
    guard = 0;
    while ((exp_data_q.size() > 0) && (guard < 50)) begin
      @(negedge clk);
      guard++;
    end
    check_output("drain_empty", exp_data_q.size(), 0);
    set_mode(0);
    idle(2);
    exp_b = 8'h00;
    total = 0;
    for (int k = 0; k < got_data_q.size(); k++) begin
      for (int ln = 0; ln < L; ln++) begin
        if (got_mask_q[k][ln]) begin
          check_output("unpack_beat", got_data_q[k][ln*W +: W], exp_b);
          exp_b = exp_b + 8'd1;
          total++;
        end
      end
    end
    check_output("unpack_total", total, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
